// File: rtl/bit_serial_adder_if.sv
// rtl/bit_serial_adder_if.sv - start/busy/done handshake and operand/result bus for bit_serial_adder
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a_in, b_in,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - bit-serial N-bit adder, LSB first, one bit per clock
module bit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    bit_serial_adder_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry;
    logic             carry_next;
    logic [CNT_W-1:0] cnt;

    logic             ha_sum;
    logic             ha_carry;
    logic             bit_s;
    logic             accept;
    logic             last_bit;

    // Half-adder on the current LSBs, extended with the registered carry-in
    always_comb begin
        ha_sum     = sa[0] ^ sb[0];
        ha_carry   = sa[0] & sb[0];
        bit_s      = ha_sum ^ carry;
        carry_next = ha_carry | (carry & ha_sum);
        sr_next             = sr >> 1;
        sr_next[WIDTH-1]    = bit_s;
    end

    // A new operation can begin from IDLE or straight out of DONE
    assign accept   = bus.start && ((state == IDLE) || (state == DONE));
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_next = ADD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, serial shifting, carry feedback and result publication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            sa    <= bus.a_in;
            sb    <= bus.b_in;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == ADD) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            sr    <= sr_next;
            carry <= carry_next;
            cnt   <= cnt + CNT_W'(1);
            // Final bit: publish the completed result; sum/cout stay frozen otherwise
            if (last_bit) begin
                sum_q  <= sr_next;
                cout_q <= carry_next;
            end
        end
    end

    assign bus.busy = (state == ADD);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=1)
module tb_bit_serial_adder;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bit_serial_adder_if #(.WIDTH(8)) if8 ();
    bit_serial_adder_if #(.WIDTH(1)) if1 ();

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one start pulse on the 8-bit instance; returns 1 time unit after the accepting edge
    task automatic launch8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        if8.start = 1'b1;
        if8.a_in  = a;
        if8.b_in  = b;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        if8.start = 1'b0;
        if8.a_in  = '0;
        if8.b_in  = '0;
        if1.start = 1'b0;
        if1.a_in  = '0;
        if1.b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (if8.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", if8.busy); end
        total++;
        if (if8.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", if8.done); end
        total++;
        if (if8.sum !== 8'd0) begin bad++; $display("FAIL reset_sum: got %0d want 0", if8.sum); end
        total++;
        if (if8.cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", if8.cout); end
        total++;
        if ({if1.busy, if1.done, if1.cout, if1.sum} !== 4'b0000) begin
            bad++; $display("FAIL reset_w1: got %b want 0000", {if1.busy, if1.done, if1.cout, if1.sum});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        launch8(8'd3, 8'd5);
        total++;
        if (if8.busy !== 1'b1 || if8.done !== 1'b0) begin
            bad++; $display("FAIL basic_first_cycle: busy=%b done=%b want busy=1 done=0", if8.busy, if8.done);
        end
        for (int k = 1; k < 8; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (if8.busy !== 1'b1 || if8.done !== 1'b0 || if8.sum !== 8'd0) begin
                bad++;
                $display("FAIL basic_add_cycle%0d: busy=%b done=%b sum=%0d want busy=1 done=0 sum=0",
                         k, if8.busy, if8.done, if8.sum);
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (if8.done !== 1'b1 || if8.busy !== 1'b0 || {if8.cout, if8.sum} !== 9'd8) begin
            bad++;
            $display("FAIL basic_done: done=%b busy=%b cout=%b sum=%0d want done=1 busy=0 cout=0 sum=8",
                     if8.done, if8.busy, if8.cout, if8.sum);
        end
        @(posedge clk);
        #1;
        total++;
        if (if8.done !== 1'b0 || if8.sum !== 8'd8) begin
            bad++; $display("FAIL basic_hold: done=%b sum=%0d want done=0 sum=8", if8.done, if8.sum);
        end
    endtask

    task automatic test_corners;
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic [8:0] exp;
        ta = '{8'd255, 8'd255, 8'd0};
        tb = '{8'd1,   8'd255, 8'd0};
        for (int i = 0; i < 3; i++) begin
            exp = {1'b0, ta[i]} + {1'b0, tb[i]};
            launch8(ta[i], tb[i]);
            repeat (8) @(posedge clk);
            #1;
            total++;
            if (if8.done !== 1'b1 || {if8.cout, if8.sum} !== exp) begin
                bad++;
                $display("FAIL corner_%0d_plus_%0d: done=%b result=%0d want done=1 result=%0d",
                         ta[i], tb[i], if8.done, {if8.cout, if8.sum}, exp);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int         done_cnt;
        int         done_at;
        int         restarted;
        logic [8:0] res;
        done_cnt  = 0;
        done_at   = -1;
        restarted = 0;
        res       = '0;
        launch8(8'd10, 8'd20);
        repeat (3) @(posedge clk);
        @(negedge clk);
        if8.start = 1'b1;
        if8.a_in  = 8'd1;
        if8.b_in  = 8'd1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        for (int c = 5; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (if8.done === 1'b1) begin
                done_cnt++;
                done_at = c;
                res     = {if8.cout, if8.sum};
            end
            if (c > 8 && if8.busy !== 1'b0) restarted = 1;
        end
        total++;
        if (done_cnt !== 1 || done_at !== 8) begin
            bad++; $display("FAIL ignore_done_timing: pulses=%0d at=%0d want pulses=1 at=8", done_cnt, done_at);
        end
        total++;
        if (res !== 9'd30) begin
            bad++; $display("FAIL ignore_sum: got %0d want 30", res);
        end
        total++;
        if (restarted !== 0) begin
            bad++; $display("FAIL ignore_restart: busy seen after done, got %0d want 0", restarted);
        end
    endtask

    task automatic test_back_to_back;
        int early_done;
        early_done = 0;
        @(negedge clk);
        if8.start = 1'b1;
        if8.a_in  = 8'd100;
        if8.b_in  = 8'd27;
        @(posedge clk);
        #1;
        if8.a_in  = 8'd200;
        if8.b_in  = 8'd100;
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (if8.done !== 1'b1 || {if8.cout, if8.sum} !== 9'd127) begin
            bad++;
            $display("FAIL b2b_first: done=%b result=%0d want done=1 result=127", if8.done, {if8.cout, if8.sum});
        end
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        total++;
        if (if8.busy !== 1'b1) begin
            bad++; $display("FAIL b2b_restart: busy=%b want 1", if8.busy);
        end
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            if (if8.done !== 1'b0) early_done++;
        end
        @(posedge clk);
        #1;
        total++;
        if (early_done !== 0 || if8.done !== 1'b1 || {if8.cout, if8.sum} !== 9'd300) begin
            bad++;
            $display("FAIL b2b_second: early=%0d done=%b result=%0d want early=0 done=1 result=300",
                     early_done, if8.done, {if8.cout, if8.sum});
        end
    endtask

    task automatic test_reset_mid;
        int spurious;
        spurious = 0;
        launch8(8'd77, 8'd88);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({if8.busy, if8.done, if8.cout, if8.sum} !== 11'd0) begin
            bad++;
            $display("FAIL midreset_async: busy=%b done=%b cout=%b sum=%0d want all 0",
                     if8.busy, if8.done, if8.cout, if8.sum);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (if8.done !== 1'b0 || if8.busy !== 1'b0) spurious++;
        end
        total++;
        if (spurious !== 0) begin
            bad++; $display("FAIL midreset_no_done: activity cycles=%0d want 0", spurious);
        end
        launch8(8'd1, 8'd2);
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (if8.done !== 1'b1 || {if8.cout, if8.sum} !== 9'd3) begin
            bad++;
            $display("FAIL midreset_after: done=%b result=%0d want done=1 result=3", if8.done, {if8.cout, if8.sum});
        end
    endtask

    task automatic test_width1;
        logic [1:0] exp;
        for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
                exp = 2'(a + b);
                @(negedge clk);
                if1.start = 1'b1;
                if1.a_in  = 1'(a);
                if1.b_in  = 1'(b);
                @(posedge clk);
                #1;
                if1.start = 1'b0;
                total++;
                if (if1.busy !== 1'b1 || if1.done !== 1'b0) begin
                    bad++; $display("FAIL w1_add_%0d%0d: busy=%b done=%b want busy=1 done=0", a, b, if1.busy, if1.done);
                end
                @(posedge clk);
                #1;
                total++;
                if (if1.done !== 1'b1 || {if1.cout, if1.sum} !== exp) begin
                    bad++;
                    $display("FAIL w1_done_%0d%0d: done=%b result=%b want done=1 result=%b",
                             a, b, if1.done, {if1.cout, if1.sum}, exp);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] exp;
        int         coinc;
        int         got;
        coinc = 0;
        for (int i = 0; i < 1000; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            exp = 9'(a) + 9'(b);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
            end
            launch8(a, b);
            got = 0;
            for (int k = 0; k < 20 && got == 0; k++) begin
                @(negedge clk);
                if8.a_in = 8'($urandom);
                if8.b_in = 8'($urandom);
                @(posedge clk);
                #1;
                if (if8.busy === 1'b1 && if8.done === 1'b1) coinc++;
                if (if8.done === 1'b1) got = 1;
            end
            total++;
            if (got == 0) begin
                bad++; $display("FAIL rand_timeout_%0d: no done for %0d+%0d", i, a, b);
            end else if ({if8.cout, if8.sum} !== exp) begin
                bad++; $display("FAIL rand_%0d: %0d+%0d got %0d want %0d", i, a, b, {if8.cout, if8.sum}, exp);
            end
        end
        total++;
        if (coinc !== 0) begin
            bad++; $display("FAIL rand_busy_done_overlap: got %0d cycles want 0", coinc);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_corners();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
